dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter FSM: IDLE accepts a request, BUSY performs the single memory cycle.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Master index: 0 = core data port, 1 = debug/DMA port.
  typedef logic master_idx_t;

  // Default RAM window, compared against addr[31:28].
  localparam logic [3:0] RamRegionDefault = 4'h8;

  // One latched access as presented by the winning master.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  // True when the address falls inside the RAM window.
  function automatic logic addr_in_region(input logic [31:0] addr, input logic [3:0] region);
    return addr[31:28] == region;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: turns a request pair plus a priority pointer
// into a one-hot (or empty) grant. Purely combinational; the pointer register
// lives in the parent.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t prio,  // master that wins a tie
  output logic [1:0]  gnt
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for two masters (core data port and debug/DMA port).
// One access every two cycles: grant in IDLE, memory cycle in BUSY, and a
// one-cycle rvalid pulse to the owner on the cycle after BUSY. Accesses whose
// address falls outside the RAM window write nothing and return err=1, rdata=0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [3:0]  RAM_REGION = RamRegionDefault,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam master_idx_t ResetPrio = master_idx_t'(RESET_PRIO != 0);

  state_e      state_q, state_d;
  master_idx_t prio_q, prio_d;
  master_idx_t owner_q;
  mem_req_t    req_q, sel_req;

  logic [1:0]  arb_gnt;
  logic [1:0]  gnt;
  master_idx_t gnt_idx;
  logic        accept;
  logic        busy;
  logic        req_in_region;

  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  rr_arbiter2 u_rr_arbiter2 (
    .req  ({m1_req, m0_req}),
    .prio (prio_q),
    .gnt  (arb_gnt)
  );

  assign busy          = (state_q == StBusy);
  assign req_in_region = addr_in_region(req_q.addr, RAM_REGION);

  // The state register already reads IDLE while reset is held, so reset must
  // mask the combinational grant explicitly.
  assign gnt     = (!busy && !reset) ? arb_gnt : 2'b00;
  assign accept  = |gnt;
  assign gnt_idx = gnt[1];
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  // Select the winning master's access fields for latching.
  always_comb begin
    sel_req.we    = m0_we;
    sel_req.addr  = m0_addr;
    sel_req.wdata = m0_wdata;
    sel_req.wmask = m0_wmask;
    if (gnt_idx) begin
      sel_req.we    = m1_we;
      sel_req.addr  = m1_addr;
      sel_req.wdata = m1_wdata;
      sel_req.wmask = m1_wmask;
    end
  end

  // Next state and priority pointer: the master just granted drops to lowest.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          prio_d  = ~gnt_idx;
        end
      end
      StBusy:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= ResetPrio;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Capture the granted access; held afterwards so mem_addr/mem_wdata stay put in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      owner_q <= 1'b0;
    end else if (accept) begin
      req_q   <= sel_req;
      owner_q <= gnt_idx;
    end
  end

  // Register the completion at the end of BUSY; owner_q is still valid in the
  // rvalid cycle because a new grant only overwrites it at the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= busy;
      if (busy) begin
        rdata_q <= req_in_region ? mem_rdata : 32'h0;
        err_q   <= !req_in_region;
      end
    end
  end

  // Memory port: only BUSY may write, and never outside the RAM window.
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_we    = (busy && req_q.we && req_in_region) ? req_q.wmask : 4'b0000;

  // Response fan-out; non-owners see zeros.
  assign m0_rvalid = rvalid_q && (owner_q == 1'b0);
  assign m1_rvalid = rvalid_q && (owner_q == 1'b1);
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

  // Arbitration contract.
  gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  busy_once_a:  assert property (@(posedge clk) disable iff (reset) busy |=> !busy);
  no_gnt_busy_a: assert property (@(posedge clk) disable iff (reset) busy |-> (gnt == 2'b00));
  we_busy_a:    assert property (@(posedge clk) disable iff (reset) !busy |-> (mem_we == 4'b0000));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level model (grant slots, one access in
// flight, word-addressed memory image).
module tb_dmem_arbiter;

  localparam logic [3:0] Region    = 4'h8;
  localparam int         ResetPrio = 0;

  logic clk = 1'b0;
  logic reset;

  logic        drv_req   [2];
  logic        drv_we    [2];
  logic [31:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic [3:0]  drv_wmask [2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] phys [64];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .RAM_REGION (Region),
    .RESET_PRIO (ResetPrio)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (drv_req[0]),
    .m0_we     (drv_we[0]),
    .m0_addr   (drv_addr[0]),
    .m0_wdata  (drv_wdata[0]),
    .m0_wmask  (drv_wmask[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (drv_req[1]),
    .m1_we     (drv_we[1]),
    .m1_addr   (drv_addr[1]),
    .m1_wdata  (drv_wdata[1]),
    .m1_wmask  (drv_wmask[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h9E37_79B9 * 32'(i) + 32'h0000_1234;
  endfunction

  // Physical data memory: combinational read, byte-lane write on the clock edge.
  assign mem_rdata = phys[mem_addr[7:2]];
  initial for (int i = 0; i < 64; i++) phys[i] <= init_word(i);
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) phys[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Scoreboard counters.
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state.
  logic [31:0] mm [64];
  int          free_at, last_m;
  bit          acc_pend, rsp_pend;
  int          acc_cyc, acc_m, rsp_cyc, rsp_m;
  logic        acc_we, rsp_we, rsp_err;
  logic [31:0] acc_addr, acc_wdata, rsp_data;
  logic [3:0]  acc_wmask;

  // Observations of DUT behaviour for directed checks and driver handshakes.
  bit          got_gnt  [2];
  bit          rsp_seen [2];
  int          gnt_cyc  [2];
  int          rv_cyc   [2];
  logic [31:0] obs_rdata[2];
  logic        obs_err  [2];
  bit          obs_we_any;
  logic [3:0]  obs_we_val;
  int          we_cyc, gnt_events, last_gnt_m, prev_gnt_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d obs=%08h exp=%08h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: compare, advance model,
  // then move to the next falling edge.
  task automatic run_cycle();
    logic [1:0]  og, orv, eg, erv;
    logic [3:0]  ewe;
    logic        inreg;
    logic [5:0]  idx;
    int          w;
    #1;
    cyc++;
    og  = {m1_gnt, m0_gnt};
    orv = {m1_rvalid, m0_rvalid};
    if (og != 2'b00) begin
      w = og[1] ? 1 : 0;
      got_gnt[w] = 1'b1;
      gnt_cyc[w] = cyc;
      prev_gnt_m = last_gnt_m;
      last_gnt_m = w;
      gnt_events++;
    end
    if (mem_we != 4'b0000) begin
      obs_we_any = 1'b1;
      obs_we_val = mem_we;
      we_cyc     = cyc;
    end
    for (int m = 0; m < 2; m++) begin
      if (orv[m]) begin
        rsp_seen[m]  = 1'b1;
        rv_cyc[m]    = cyc;
        obs_rdata[m] = (m == 1) ? m1_rdata : m0_rdata;
        obs_err[m]   = (m == 1) ? m1_err : m0_err;
      end
    end

    if (reset) begin
      check_eq("rst_gnt", 32'(og), 32'h0);
      check_eq("rst_rvalid", 32'(orv), 32'h0);
      check_eq("rst_mem_we", 32'(mem_we), 32'h0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      check_eq("rst_err", 32'({m1_err, m0_err}), 32'h0);
      acc_pend = 1'b0;
      rsp_pend = 1'b0;
      last_m   = -1;
      free_at  = 0;
    end else begin
      // Grant: a slot opens two cycles after the previous grant.
      eg = 2'b00;
      w  = 0;
      if (cyc >= free_at && (drv_req[0] || drv_req[1])) begin
        if (drv_req[0] && drv_req[1]) w = (last_m < 0) ? ResetPrio : 1 - last_m;
        else                          w = drv_req[1] ? 1 : 0;
        eg[w] = 1'b1;
      end
      check_eq("gnt", 32'(og), 32'(eg));

      // Memory access cycle.
      ewe = 4'b0000;
      if (acc_pend && acc_cyc == cyc) begin
        inreg = (acc_addr[31:28] == Region);
        if (acc_we && inreg) ewe = acc_wmask;
        check_eq("mem_addr", 32'(mem_addr[31:2]), 32'(acc_addr[31:2]));
        if (acc_we) check_eq("mem_wdata", mem_wdata, acc_wdata);
      end
      check_eq("mem_we", 32'(mem_we), 32'(ewe));

      // Completion pulse.
      erv = 2'b00;
      if (rsp_pend && rsp_cyc == cyc) erv[rsp_m] = 1'b1;
      check_eq("rvalid", 32'(orv), 32'(erv));
      if (rsp_pend && rsp_cyc == cyc) begin
        check_eq("err", 32'((rsp_m == 1) ? m1_err : m0_err), 32'(rsp_err));
        if (!rsp_we) check_eq("rdata", (rsp_m == 1) ? m1_rdata : m0_rdata, rsp_data);
        rsp_pend = 1'b0;
      end

      // Commit the access that completes at the end of this cycle.
      if (acc_pend && acc_cyc == cyc) begin
        inreg    = (acc_addr[31:28] == Region);
        idx      = acc_addr[7:2];
        rsp_data = inreg ? mm[idx] : 32'h0;
        rsp_err  = !inreg;
        rsp_we   = acc_we;
        rsp_m    = acc_m;
        if (acc_we && inreg)
          for (int b = 0; b < 4; b++)
            if (acc_wmask[b]) mm[idx][8*b +: 8] = acc_wdata[8*b +: 8];
        rsp_pend = 1'b1;
        rsp_cyc  = cyc + 1;
        acc_pend = 1'b0;
      end

      if (eg != 2'b00) begin
        acc_pend  = 1'b1;
        acc_cyc   = cyc + 1;
        acc_m     = w;
        acc_we    = drv_we[w];
        acc_addr  = drv_addr[w];
        acc_wdata = drv_wdata[w];
        acc_wmask = drv_wmask[w];
        last_m    = w;
        free_at   = cyc + 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int m, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm);
    drv_req[m]   = 1'b1;
    drv_we[m]    = we;
    drv_addr[m]  = a;
    drv_wdata[m] = wd;
    drv_wmask[m] = wm;
    got_gnt[m]   = 1'b0;
    rsp_seen[m]  = 1'b0;
  endtask

  task automatic wait_gnt(input int m);
    for (int k = 0; k < 16 && !got_gnt[m]; k++) run_cycle();
    check_eq($sformatf("gnt_wait_m%0d", m), 32'(got_gnt[m]), 32'h1);
    drv_req[m] = 1'b0;
  endtask

  task automatic wait_rsp(input int m);
    for (int k = 0; k < 8 && !rsp_seen[m]; k++) run_cycle();
    check_eq($sformatf("rsp_wait_m%0d", m), 32'(rsp_seen[m]), 32'h1);
  endtask

  task automatic do_acc(input int m, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm);
    issue(m, we, a, wd, wm);
    obs_we_any = 1'b0;
    wait_gnt(m);
    wait_rsp(m);
  endtask

  task automatic rand_req(input int m);
    logic [31:0] a;
    if ($urandom_range(0, 3) != 0) begin
      a = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    end else begin
      a = $urandom;
      if (a[31:28] == Region) a[31:28] = 4'h3;
    end
    issue(m, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ev0, n_alt;
    for (int i = 0; i < 64; i++) mm[i] = init_word(i);
    for (int m = 0; m < 2; m++) begin
      drv_req[m] = 1'b0; drv_we[m] = 1'b0; drv_addr[m] = '0;
      drv_wdata[m] = '0; drv_wmask[m] = '0;
      got_gnt[m] = 1'b0; rsp_seen[m] = 1'b0;
    end
    free_at = 0; last_m = -1; acc_pend = 1'b0; rsp_pend = 1'b0;
    gnt_events = 0; last_gnt_m = -1; prev_gnt_m = -1;
    reset = 1'b1;
    @(negedge clk);

    // Reset holds everything quiet even with requests pending.
    issue(0, 1'b0, 32'h8000_0000, '0, '0);
    issue(1, 1'b1, 32'h8000_0004, 32'h1, 4'hF);
    run_cycle();
    run_cycle();
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    reset = 1'b0;
    run_cycle();

    // Full-word store then load; latency T / T+1 / T+2.
    do_acc(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
    check_eq("r036_we_val", 32'(obs_we_val), 32'hF);
    check_eq("r036_we_lat", 32'(we_cyc - gnt_cyc[0]), 32'd1);
    check_eq("r036_rv_lat", 32'(rv_cyc[0] - gnt_cyc[0]), 32'd2);
    check_eq("r036_err", 32'(obs_err[0]), 32'h0);
    do_acc(0, 1'b0, 32'h8000_0010, '0, '0);
    check_eq("r036_load", obs_rdata[0], 32'hDEAD_BEEF);

    // Out-of-region store.
    do_acc(1, 1'b1, 32'h0000_0004, 32'h55AA_55AA, 4'b1111);
    check_eq("r038_no_we", 32'(obs_we_any), 32'h0);
    check_eq("r038_err", 32'(obs_err[1]), 32'h1);
    check_eq("r038_rdata", obs_rdata[1], 32'h0);

    // Byte-lane merge, then an empty-mask store that must not write.
    do_acc(0, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'b1111);
    do_acc(0, 1'b1, 32'h8000_0040, 32'h0000_00AA, 4'b0001);
    do_acc(0, 1'b0, 32'h8000_0040, '0, '0);
    check_eq("r039_merge", obs_rdata[0], 32'h1122_33AA);
    do_acc(1, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'b0000);
    check_eq("r028_no_we", 32'(obs_we_any), 32'h0);
    check_eq("r028_err", 32'(obs_err[1]), 32'h0);
    do_acc(1, 1'b0, 32'h8000_0040, '0, '0);
    check_eq("r028_unchanged", obs_rdata[1], 32'h1122_33AA);

    // Continuous loads from both masters straight out of reset.
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    issue(0, 1'b0, 32'h8000_0000, '0, '0);
    issue(1, 1'b0, 32'h8000_0004, '0, '0);
    ev0   = gnt_events;
    n_alt = 0;
    for (int k = 0; k < 24; k++) begin
      run_cycle();
      if (gnt_events != ev0) begin
        if (n_alt == 0) check_eq("r037_first", 32'(last_gnt_m), 32'h0);
        else            check_eq("r037_alt", 32'(last_gnt_m != prev_gnt_m), 32'h1);
        n_alt++;
        ev0 = gnt_events;
        for (int m = 0; m < 2; m++)
          if (got_gnt[m]) issue(m, 1'b0, 32'h8000_0000 + 32'(4 * k), '0, '0);
      end
    end
    check_eq("r037_count", 32'(n_alt), 32'd12);
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    repeat (3) run_cycle();

    // Pointer moves to m1 after an m0 win; reset must restore m0 priority.
    issue(0, 1'b0, 32'h8000_0000, '0, '0);
    issue(1, 1'b0, 32'h8000_0000, '0, '0);
    run_cycle();
    check_eq("prio_pre_tie", 32'({got_gnt[1], got_gnt[0]}), 32'h1);
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    repeat (3) run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    issue(0, 1'b0, 32'h8000_0000, '0, '0);
    issue(1, 1'b0, 32'h8000_0000, '0, '0);
    run_cycle();
    check_eq("prio_post_rst", 32'({got_gnt[1], got_gnt[0]}), 32'h1);
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    repeat (3) run_cycle();

    // Reset during the BUSY cycle of an m1 store aborts it.
    issue(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111);
    wait_gnt(1);
    reset = 1'b1;
    #1;
    check_eq("r040_we_drop", 32'(mem_we), 32'h0);
    @(negedge clk);
    run_cycle();
    reset = 1'b0;
    rsp_seen[1] = 1'b0;
    repeat (3) run_cycle();
    check_eq("r040_no_rvalid", 32'(rsp_seen[1]), 32'h0);
    issue(0, 1'b0, 32'h8000_0020, '0, '0);
    issue(1, 1'b0, 32'h8000_0020, '0, '0);
    run_cycle();
    check_eq("r040_tie_m0", 32'({got_gnt[1], got_gnt[0]}), 32'h1);
    drv_req[0] = 1'b0;
    wait_gnt(1);
    wait_rsp(1);
    check_eq("r040_word_m0", obs_rdata[0], init_word(8));
    check_eq("r040_word_m1", obs_rdata[1], init_word(8));

    // Randomized traffic with request drops and occasional resets.
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!drv_req[m] || got_gnt[m]) begin
          if ($urandom_range(0, 9) < 6) rand_req(m);
          else begin
            drv_req[m] = 1'b0;
            got_gnt[m] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          drv_req[m] = 1'b0;
        end
      end
      run_cycle();
    end
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    repeat (4) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
